led_blink_sched: RTL and testbench
==================================

# led_blink_sched

Two-requester scheduler for the shared 8-bit LED bank on the remote-blink board. It arbitrates between two independent pattern sources, e.g. the remote-command decoder and the local demo sequencer. It owns the LED bank for the duration of one granted job: the pattern is blinked a requested number of times at a fixed rate, then `done` is pulsed and the scheduler re-arbitrates.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `BLINK_HZ`, 2: blink rate. Half-period H = CLK_FREQ/(2*BLINK_HZ) cycles. H >= 1 is required.
- `clk` in, 1 bit: clock, rising edge.
- `rst_n` in, 1 bit: reset, synchronous, active-low. Clock is `clk`.
- `req` in, 2 bits: per-requester job request, level.
- `pat0`, `pat1` in, 8 bits each: LED pattern of requester 0/1. Must be stable while the corresponding `req` bit is high.
- `cnt0`, `cnt1` in, 3 bits each: blink count of requester 0/1. Value 0 means 8 blinks.
- `gnt` out, 2 bits: one-cycle acceptance pulse, one-hot.
- `busy` out, 1 bit: high while a job owns the LEDs.
- `done` out, 1 bit: one-cycle pulse at job completion.
- `leds` out, 8 bits: LED drive.

## Operation
- All outputs are registered.
- Reset values:
  - `gnt`=0, `busy`=0, `done`=0, `leds`=0.
  - State IDLE, timer 0, blink counter 0.
  - Round-robin pointer set to "last granted = 1", so requester 0 wins the first tie.
- States: IDLE, ON, OFF.
- **IDLE**, when `req` != 0 at a rising edge:
  - The winner's `pat`/`cnt` are latched at that edge. The effective count is n = (cnt==0) ? 8 : cnt, held in a 4-bit counter.
  - `gnt[winner]` is set to 1 for exactly one cycle.
  - `busy` is set to 1 and `leds` is set to the pattern.
  - Timer is cleared; next state is ON.
- **ON**: `leds` = latched pattern for H cycles, then `leds` = 0 and the state goes to OFF.
- **OFF**: `leds` = 0 for H cycles. Then:
  - If this was blink n, the state goes to IDLE, `busy` = 0 and `done` = 1 for one cycle.
  - Otherwise the blink counter increments, `leds` = pattern, and the state goes to ON.
- `req` is ignored while `busy`. No `gnt` is issued, and pending requests wait.
- The requester must drop `req` in the cycle after seeing its `gnt`. A `req` still high at the next IDLE edge is treated as a new job.
- Arbitration on a tie (`req` = 2'b11) is round-robin: grant the requester not granted last. The pointer updates only on a grant.
- Timer is 32 bits and counts 0..H-1. Pattern changes on `pat0`/`pat1` after the grant have no effect on the running job.
- Reset mid-job:
  - At the reset edge the job is aborted: `leds` = 0, `busy` = 0, no `done` pulse.
  - The arbiter pointer returns to its reset value.

## Timing
- Grant at edge E0: `gnt` and `busy` are high, and `leds` = pattern, in the cycle after E0.
- Blink k (k = 0..n-1):
  - `leds` = pattern from edge E0+2kH for H cycles.
  - `leds` = 0 from edge E0+(2k+1)H for H cycles.
- At edge E0+2nH: `busy` goes to 0 and `done` goes to 1 for one cycle.
- Earliest next grant is at edge E0+2nH+1, so IDLE always lasts at least one cycle between jobs.
- Total job length is 2nH cycles.
- Latency from `req` to `gnt` while idle is 1 cycle, i.e. registered at the sampling edge.

## Configuration
- `LED_SCHED_RR_EN` defined: round-robin tie-break as described in Operation.
- `LED_SCHED_RR_EN` undefined:
  - Fixed priority: requester 0 always wins a tie.
  - The pointer register is removed.
  - All other behaviour is unchanged.

## Test plan
All scenarios use CLK_FREQ=8, BLINK_HZ=1, so H=4.
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=2'b11. Required: `gnt`=0, `busy`=0, `done`=0, `leds`=0 throughout.
- **Single job:** `req`=2'b01, `pat0`=0x0F, `cnt0`=2. Required:
  - `gnt`=01 for 1 cycle.
  - `leds` = 0x0F for 4 cycles, 0 for 4, 0x0F for 4, 0 for 4.
  - `done` pulses 16 cycles after the grant edge and `busy` falls with it.
- **Tie:** `req`=2'b11 held, `cnt0`=`cnt1`=1. Required:
  - With `LED_SCHED_RR_EN`: grants 01,10,01,10, spaced 9 cycles apart.
  - Without it: grants 01,01,01.
- **Count wrap:** `cnt1`=0, `pat1`=0xA5. Required: 8 blinks of 0xA5, `done` 64 cycles after grant.
- **Request while busy:** assert `req[1]` during requester 0's ON phase. Required: no `gnt` until `done`, then `gnt`=10 exactly 1 cycle after `done`.
- **Reset mid-job:** assert `rst_n`=0 during an ON phase with `leds`=0x3C. Required:
  - `leds`=0 and `busy`=0 after the reset edge, with no `done`.
  - After reset, with `req`=2'b11, `gnt`=01.

Source files
------------

// File: rtl/led_blink_sched_if.sv
// Request/grant and LED-drive bundle shared by the two pattern sources and the
// LED bank scheduler.
interface led_blink_sched_if;
  logic [1:0] req;
  logic [7:0] pat0;
  logic [7:0] pat1;
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic [7:0] leds;

  modport master (
    output req, pat0, pat1, cnt0, cnt1,
    input  gnt, busy, done, leds
  );

  modport slave (
    input  req, pat0, pat1, cnt0, cnt1,
    output gnt, busy, done, leds
  );
endinterface

// File: rtl/led_blink_sched.sv
// Two-requester LED bank scheduler: grants one job, blinks its pattern n times, pulses done.
// Define LED_SCHED_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module led_blink_sched #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  led_blink_sched_if.slave  bus
);

  localparam int unsigned H      = CLK_FREQ / (2 * BLINK_HZ);
  localparam logic [31:0] H_LAST = 32'(H - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [3:0]  blk_q, blk_d;
  logic [3:0]  num_q, num_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  leds_q, leds_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        win;
  logic [2:0]  cnt_sel;
  logic        tmr_end;

`ifdef LED_SCHED_RR_EN
  logic last_q, last_d;
`endif

  // Winner index: requester 1 only when it asks alone, unless round-robin flips a tie.
  always_comb begin
    win = bus.req[1] & ~bus.req[0];
`ifdef LED_SCHED_RR_EN
    if (bus.req == 2'b11) win = ~last_q;
`endif
  end

  assign cnt_sel = win ? bus.cnt1 : bus.cnt0;
  assign tmr_end = (tmr_q == H_LAST);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    blk_d   = blk_q;
    num_d   = num_q;
    pat_d   = pat_q;
    leds_d  = leds_q;
    gnt_d   = 2'b00;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef LED_SCHED_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          pat_d   = win ? bus.pat1 : bus.pat0;
          num_d   = (cnt_sel == 3'd0) ? 4'd8 : {1'b0, cnt_sel};
          blk_d   = 4'd0;
          tmr_d   = 32'd0;
          leds_d  = pat_d;
          busy_d  = 1'b1;
          state_d = ON;
`ifdef LED_SCHED_RR_EN
          last_d  = win;
`endif
        end
      end
      ON: begin
        if (tmr_end) begin
          tmr_d   = 32'd0;
          leds_d  = 8'h00;
          state_d = OFF;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      OFF: begin
        if (tmr_end) begin
          tmr_d = 32'd0;
          if (blk_q + 4'd1 == num_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            blk_d   = blk_q + 4'd1;
            leds_d  = pat_q;
            state_d = ON;
          end
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any running job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 32'd0;
      blk_q   <= 4'd0;
      leds_q  <= 8'h00;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      blk_q   <= blk_d;
      leds_q  <= leds_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LED_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Latched job data, only meaningful while busy.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    num_q <= num_d;
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.leds = leds_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched (H=4): expected output transitions are queued
// with their cycle numbers and matched by an independent monitor.
module tb_led_blink_sched;

  localparam int H = 4;

  typedef struct packed {
    int         cyc;
    logic [11:0] val;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_q = 1'b0;
  int   cyc = 0;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   end_chk = 1'b0;
  bit   chk_done = 1'b0;
  int   e0;
  int   last_e;

  led_blink_sched_if dut_if ();

  led_blink_sched #(.CLK_FREQ(8), .BLINK_HZ(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic push(input int c, input logic [11:0] v);
    rec_t r;
    r.cyc = c;
    r.val = v;
    exp_q.push_back(r);
  endtask

  // Transitions of {gnt, busy, done, leds} for one job granted at edge e.
  task automatic push_job(input int e, input logic [1:0] g, input logic [7:0] p,
                          input int n, input bit tail);
    push(e,     {g, 2'b10, p});
    push(e + 1, {4'b0010, p});
    push(e + H, {4'b0010, 8'h00});
    for (int k = 1; k < n; k++) begin
      push(e + 2*k*H,     {4'b0010, p});
      push(e + (2*k+1)*H, {4'b0010, 8'h00});
    end
    push(e + 2*n*H, {4'b0001, 8'h00});
    if (tail) push(e + 2*n*H + 1, 12'h000);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: zero check under reset, otherwise match every output change.
  initial begin : monitor
    logic [11:0] cur;
    logic [11:0] prev;
    rec_t        r;
    prev = 12'h000;
    forever begin
      @(negedge clk);
      cur = {dut_if.gnt, dut_if.busy, dut_if.done, dut_if.leds};
      if (!rst_q) begin
        n_cmp++;
        if (cur !== 12'h000) begin
          n_bad++;
          $display("FAIL reset_zero cyc=%0d: got gnt/busy/done/leds=%h, need 000", cyc, cur);
        end
      end else if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d: got %h, need no change from %h", cyc, cur, prev);
        end else begin
          r = exp_q.pop_front();
          if (r.cyc != cyc || r.val !== cur) begin
            n_bad++;
            $display("FAIL out_event: got %h at cycle %0d, need %h at cycle %0d",
                     cur, cyc, r.val, r.cyc);
          end
        end
      end
      prev = cur;
      if (end_chk && !chk_done) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL missing_events: got %0d unmatched, need 0 (next at cycle %0d)",
                   exp_q.size(), exp_q[0].cyc);
        end
        chk_done = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, need finish before 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n       = 1'b0;
    dut_if.req  = 2'b11;
    dut_if.pat0 = 8'h00;
    dut_if.pat1 = 8'h00;
    dut_if.cnt0 = 3'd0;
    dut_if.cnt1 = 3'd0;

    // Reset held three cycles with both requests up.
    wait_until(3);
    rst_n      = 1'b1;
    dut_if.req = 2'b00;

    // Single job: requester 0, two blinks of 0x0F.
    wait_until(4);
    dut_if.pat0 = 8'h0F;
    dut_if.cnt0 = 3'd2;
    dut_if.req  = 2'b01;
    e0 = cyc + 1;
    push_job(e0, 2'b01, 8'h0F, 2, 1'b1);
    wait_until(e0);
    dut_if.req = 2'b00;
    wait_until(e0 + 16 + 2);

    // Count wrap: cnt 0 means eight blinks.
    dut_if.pat1 = 8'hA5;
    dut_if.cnt1 = 3'd0;
    dut_if.req  = 2'b10;
    e0 = cyc + 1;
    push_job(e0, 2'b10, 8'hA5, 8, 1'b1);
    wait_until(e0);
    dut_if.req = 2'b00;
    wait_until(e0 + 64 + 2);

    // Tie held high.
    dut_if.pat0 = 8'h81;
    dut_if.pat1 = 8'h18;
    dut_if.cnt0 = 3'd1;
    dut_if.cnt1 = 3'd1;
    dut_if.req  = 2'b11;
    e0 = cyc + 1;
`ifdef LED_SCHED_RR_EN
    push_job(e0,      2'b01, 8'h81, 1, 1'b0);
    push_job(e0 + 9,  2'b10, 8'h18, 1, 1'b0);
    push_job(e0 + 18, 2'b01, 8'h81, 1, 1'b0);
    push_job(e0 + 27, 2'b10, 8'h18, 1, 1'b1);
    last_e = e0 + 27;
`else
    push_job(e0,      2'b01, 8'h81, 1, 1'b0);
    push_job(e0 + 9,  2'b01, 8'h81, 1, 1'b0);
    push_job(e0 + 18, 2'b01, 8'h81, 1, 1'b1);
    last_e = e0 + 18;
`endif
    wait_until(last_e);
    dut_if.req = 2'b00;
    wait_until(last_e + 10);

    // Request from 1 while 0 is busy: granted one cycle after done.
    dut_if.pat0 = 8'h66;
    dut_if.cnt0 = 3'd1;
    dut_if.req  = 2'b01;
    e0 = cyc + 1;
    push_job(e0,     2'b01, 8'h66, 1, 1'b0);
    push_job(e0 + 9, 2'b10, 8'h99, 2, 1'b1);
    wait_until(e0);
    dut_if.req = 2'b00;
    wait_until(e0 + 2);
    dut_if.pat1 = 8'h99;
    dut_if.cnt1 = 3'd2;
    dut_if.req  = 2'b10;
    wait_until(e0 + 9);
    dut_if.req = 2'b00;
    wait_until(e0 + 9 + 16 + 2);

    // Reset during ON phase of 0x3C job, then a tie must go to requester 0.
    dut_if.pat0 = 8'h3C;
    dut_if.cnt0 = 3'd3;
    dut_if.req  = 2'b01;
    e0 = cyc + 1;
    push(e0,     {2'b01, 2'b10, 8'h3C});
    push(e0 + 1, {2'b00, 2'b10, 8'h3C});
    wait_until(e0);
    dut_if.req = 2'b00;
    wait_until(e0 + 2);
    rst_n       = 1'b0;
    dut_if.pat0 = 8'h42;
    dut_if.cnt0 = 3'd1;
    dut_if.cnt1 = 3'd1;
    dut_if.req  = 2'b11;
    wait_until(e0 + 4);
    rst_n = 1'b1;
    push_job(e0 + 5, 2'b01, 8'h42, 1, 1'b1);
    wait_until(e0 + 5);
    dut_if.req = 2'b00;
    wait_until(e0 + 5 + 8 + 3);

    end_chk = 1'b1;
    while (!chk_done) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
